// File: rtl/mult_if.sv
// Request/operand/result bundle between the control unit and the sequential multiplier.
// The multU request bit exists only when MULT_UNSIGNED_EN is defined.
interface mult_if #(
  parameter int WIDTH = 32
);
  logic             multOp;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] mult_hi;
  logic [WIDTH-1:0] mult_lo;
  logic             mult_done;
`ifdef MULT_UNSIGNED_EN
  logic             multU;

  modport master (output multOp, output multiplicand, output multiplier, output multU,
                  input mult_hi, input mult_lo, input mult_done);
  modport slave  (input multOp, input multiplicand, input multiplier, input multU,
                  output mult_hi, output mult_lo, output mult_done);
`else
  modport master (output multOp, output multiplicand, output multiplier,
                  input mult_hi, input mult_lo, input mult_done);
  modport slave  (input multOp, input multiplicand, input multiplier,
                  output mult_hi, output mult_lo, output mult_done);
`endif
endinterface

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier: one partial product per clock, exactly WIDTH RUN cycles.
// Optional MULT_UNSIGNED_EN adds a multU request bit selecting unsigned (multu) operation.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  reset_n,
  mult_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH+1:0] mcand_r;
  logic [WIDTH+1:0] acc_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r;
  logic             signed_mode_s;
  logic             ext_bit_s;
  logic             last_s;
  logic [WIDTH+1:0] addend_s, sum_s, acc_nx_s;
  logic [WIDTH-1:0] mplier_nx_s;

`ifdef MULT_UNSIGNED_EN
  logic signed_r;
  assign signed_mode_s = signed_r;
  assign ext_bit_s     = ~bus.multU & bus.multiplicand[WIDTH-1];
`else
  assign signed_mode_s = 1'b1;
  assign ext_bit_s     = bus.multiplicand[WIDTH-1];
`endif

  assign last_s        = (cnt_r == CW'(WIDTH - 1));
  assign bus.mult_hi   = hi_r;
  assign bus.mult_lo   = lo_r;
  assign bus.mult_done = done_r;

  // One multiplication step; the multiplier MSB carries negative weight in signed mode.
  always_comb begin
    addend_s = '0;
    if (mplier_r[0]) begin
      if (last_s && signed_mode_s) begin
        addend_s = -mcand_r;
      end else begin
        addend_s = mcand_r;
      end
    end else begin
      addend_s = '0;
    end
    sum_s       = acc_r + addend_s;
    acc_nx_s    = {sum_s[WIDTH+1], sum_s[WIDTH+1:1]};
    mplier_nx_s = {sum_s[0], mplier_r[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; dropping multOp releases DONE or aborts RUN.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.multOp) state_s = RUN;
        else            state_s = IDLE;
      end
      RUN: begin
        if (!bus.multOp) state_s = IDLE;
        else if (last_s) state_s = DONE;
        else             state_s = RUN;
      end
      DONE: begin
        if (!bus.multOp) state_s = IDLE;
        else             state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath and registered result; results appear only when the final step completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_r  <= '0;
      acc_r    <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      done_r   <= 1'b0;
`ifdef MULT_UNSIGNED_EN
      signed_r <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          hi_r   <= '0;
          lo_r   <= '0;
          done_r <= 1'b0;
          if (bus.multOp) begin
            mcand_r  <= {{2{ext_bit_s}}, bus.multiplicand};
            mplier_r <= bus.multiplier;
            acc_r    <= '0;
            cnt_r    <= '0;
`ifdef MULT_UNSIGNED_EN
            signed_r <= ~bus.multU;
`endif
          end
        end
        RUN: begin
          if (!bus.multOp) begin
            acc_r  <= '0;
            cnt_r  <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
          end else begin
            acc_r    <= acc_nx_s;
            mplier_r <= mplier_nx_s;
            cnt_r    <= cnt_r + CW'(1);
            if (last_s) begin
              hi_r   <= acc_nx_s[WIDTH-1:0];
              lo_r   <= mplier_nx_s;
              done_r <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!bus.multOp) begin
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
          end
        end
        default: begin
          hi_r   <= '0;
          lo_r   <= '0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
